// File: rtl/display_pkg.sv
// Shared constants for the shift/latch/data/blank display link (serialiser and receiver).
// Contents: frame width, blank level, synchroniser depth, and a counter-width helper.
// No ports; import with display_pkg::*.
package display_pkg;

  localparam int   DISP_WIDTH       = 8;
  localparam logic DISP_BLANK_LEVEL = 1'b0;
  localparam int   DISP_SYNC_STAGES = 2;

  // Counter must represent 0..WIDTH+1 (WIDTH+1 = "too many shifts").
  function automatic int disp_cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/display_receiver_if.sv
// Link-side bundle of the display receiver: four serial link lines in, latched word and status out.
// master: drives shift/latch/data/blank and observes q/q_valid/frame_err/bit_count.
// slave : the receiver end (display_receiver).
interface display_receiver_if
  import display_pkg::*;
#(
  parameter int WIDTH = DISP_WIDTH,
  parameter int CW    = disp_cnt_width(WIDTH)
);

  logic             shift_in;
  logic             latch_in;
  logic             data_in;
  logic             blank_in;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             frame_err;
  logic [CW-1:0]    bit_count;

  modport master (
    output shift_in, latch_in, data_in, blank_in,
    input  q, q_valid, frame_err, bit_count
  );

  modport slave (
    input  shift_in, latch_in, data_in, blank_in,
    output q, q_valid, frame_err, bit_count
  );

endinterface

// File: rtl/display_receiver_sync_edge.sv
// sync_edge: STAGES-flop synchroniser for one asynchronous line, plus rising-edge detect.
// Ports: clk/rst; in_i async input; out_level_o registered synced level; out_rise_o one-cycle rise pulse.
// out_level_o and out_rise_o are aligned: the pulse coincides with the first cycle the level reads 1.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic out_level_o,
  output logic out_rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic              rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_i};
      dly_q  <= sync_q[STAGES-1];
      // Registered so the pulse lines up with dly_q, which is the exported level.
      rise_q <= sync_q[STAGES-1] & ~dly_q;
    end
  end

  assign out_level_o = dly_q;
  assign out_rise_o  = rise_q;

endmodule

// File: rtl/display_receiver.sv
// display_receiver: 74HC595-style receiver for the display link, oversampling all lines on sysclk.
// Ports: sysclk, rst (async, active-high), link (slave modport: shift/latch/data/blank in; q, q_valid,
// frame_err, bit_count out). Latch seen at edge N -> q/q_valid/frame_err at N+4; blank at N -> q at N+3.
module display_receiver
  import display_pkg::*;
#(
  parameter int   WIDTH       = DISP_WIDTH,
  parameter logic BLANK_LEVEL = DISP_BLANK_LEVEL
) (
  input  logic                 sysclk,
  input  logic                 rst,
  display_receiver_if.slave    link
);

  localparam int            CW       = disp_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  logic shift_rise, latch_rise, data_s, blank_s;
  logic shift_lvl_unused, latch_lvl_unused, data_rise_unused, blank_rise_unused;

  // data goes through the same depth as shift, so data_s is settled when shift_rise fires.
  sync_edge #(.STAGES(DISP_SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_shift (
    .clk(sysclk), .rst(rst), .in_i(link.shift_in),
    .out_level_o(shift_lvl_unused), .out_rise_o(shift_rise)
  );
  sync_edge #(.STAGES(DISP_SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_latch (
    .clk(sysclk), .rst(rst), .in_i(link.latch_in),
    .out_level_o(latch_lvl_unused), .out_rise_o(latch_rise)
  );
  sync_edge #(.STAGES(DISP_SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .clk(sysclk), .rst(rst), .in_i(link.data_in),
    .out_level_o(data_s), .out_rise_o(data_rise_unused)
  );
  // Blank resets asserted so the outputs stay dark until the line is actually seen low.
  sync_edge #(.STAGES(DISP_SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_blank (
    .clk(sysclk), .rst(rst), .in_i(link.blank_in),
    .out_level_o(blank_s), .out_rise_o(blank_rise_unused)
  );

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lat_pend_q, lat_pend_d;
  logic             err_pend_q, err_pend_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    sr_d        = sr_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    lat_pend_d  = latch_rise;
    err_pend_d  = 1'b0;
    q_d         = blank_s ? {WIDTH{BLANK_LEVEL}} : hold_q;
    q_valid_d   = lat_pend_q;
    frame_err_d = err_pend_q;

    // Newest bit enters at the top; after WIDTH shifts the first bit sits in sr[0].
    if (shift_rise) begin
      sr_d = {data_s, sr_q[WIDTH-1:1]};
    end

    if (latch_rise) begin
      // Hold takes sr before any same-cycle shift; that shift belongs to the next frame.
      hold_d     = sr_q;
      err_pend_d = (cnt_q != CNT_FULL);
      cnt_d      = shift_rise ? CW'(1) : '0;
    end else if (shift_rise && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      lat_pend_q  <= 1'b0;
      err_pend_q  <= 1'b0;
      q_q         <= {WIDTH{BLANK_LEVEL}};
      q_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      lat_pend_q  <= lat_pend_d;
      err_pend_q  <= err_pend_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign link.q         = q_q;
  assign link.q_valid   = q_valid_q;
  assign link.frame_err = frame_err_q;
  assign link.bit_count = cnt_q;

endmodule

// File: tb/tb_display_receiver.sv
// Testbench for display_receiver: directed link traffic at sysclk/4 with a bit-history reference model.
// Ports: none (top level); instantiates display_receiver_if and the DUT.
// Expected words come from the history of received bits; literal checks pin key results.
module tb_display_receiver;
  import display_pkg::*;

  localparam int W  = DISP_WIDTH;
  localparam int CW = disp_cnt_width(W);

  logic sysclk = 1'b0;
  logic rst    = 1'b1;

  display_receiver_if #(.WIDTH(W)) link ();

  display_receiver #(.WIDTH(W), .BLANK_LEVEL(DISP_BLANK_LEVEL)) dut (
    .sysclk(sysclk),
    .rst(rst),
    .link(link)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  // Reference model: every bit received since reset (pre-filled with WIDTH zeros), shifts in current frame.
  bit hist[$];
  int shifts_since;
  bit blank_m;
  bit mon_en = 1'b0;
  logic last_err;

  typedef struct packed {
    logic [W-1:0] word;
    logic         err;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w;
    int n;
    n = hist.size();
    for (int i = 0; i < W; i++) w[i] = hist[n - W + i];
    return w;
  endfunction

  function automatic int model_count();
    return (shifts_since > W + 1) ? W + 1 : shifts_since;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    shifts_since = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    link.data_in  = b;
    link.shift_in = 1'b1;
    tick(2);
    link.shift_in = 1'b0;
    tick(2);
    hist.push_back(b);
    shifts_since++;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic do_latch(input bit with_shift, input bit b);
    exp_t e;
    int n;
    e.word = model_word();
    e.err  = (shifts_since != W);
    expq.push_back(e);
    link.latch_in = 1'b1;
    if (with_shift) begin
      link.data_in  = b;
      link.shift_in = 1'b1;
    end
    tick(2);
    link.latch_in = 1'b0;
    link.shift_in = 1'b0;
    tick(2);
    shifts_since = 0;
    if (with_shift) begin
      hist.push_back(b);
      shifts_since = 1;
    end
    n = 0;
    while (expq.size() != 0 && n < 20) begin
      tick(1);
      n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL q_valid_timeout: got no q_valid expected one within 20 cycles");
      expq.delete();
    end
    tick(1);
  endtask

  // Compare process: every q_valid must match a queued expectation; frame_err never pulses alone.
  always @(negedge sysclk) begin
    if (mon_en) begin
      if (link.q_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_q_valid: got q_valid=1 expected 0 at %0t", $time);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("q_at_valid", link.q, blank_m ? {W{DISP_BLANK_LEVEL}} : e.word);
          chk("frame_err_at_valid", link.frame_err, e.err);
        end
        last_err = link.frame_err;
      end else begin
        chk("frame_err_idle", link.frame_err, 1'b0);
      end
    end
  end

  initial begin
    link.shift_in = 1'b0;
    link.latch_in = 1'b0;
    link.data_in  = 1'b0;
    link.blank_in = 1'b0;
    blank_m       = 1'b0;
    last_err      = 1'bx;
    model_reset();

    // Reset state
    tick(3);
    chk("rst_q", link.q, 0);
    chk("rst_q_valid", link.q_valid, 0);
    chk("rst_frame_err", link.frame_err, 0);
    chk("rst_bit_count", link.bit_count, 0);
    rst = 1'b0;
    tick(4);
    mon_en = 1'b1;

    // 1: clean 0xA5 frame
    send_word(8'hA5, 8);
    tick(2);
    chk("t1_bit_count_pre", link.bit_count, 8);
    chk("t1_model_count", link.bit_count, model_count());
    do_latch(1'b0, 1'b0);
    chk("t1_q", link.q, 8'hA5);
    chk("t1_err", last_err, 1'b0);
    chk("t1_bit_count_post", link.bit_count, 0);

    // 2: blank latency and restore without q_valid
    link.blank_in = 1'b1;
    blank_m = 1'b1;
    tick(3);
    chk("t2_blank_not_yet", link.q, 8'hA5);
    tick(1);
    chk("t2_blanked", link.q, 8'h00);
    link.blank_in = 1'b0;
    blank_m = 1'b0;
    tick(3);
    chk("t2_still_blank", link.q, 8'h00);
    tick(1);
    chk("t2_restored", link.q, 8'hA5);

    // 3: short frame after a zero frame
    send_word(8'h00, 8);
    do_latch(1'b0, 1'b0);
    chk("t3_zero", link.q, 8'h00);
    send_word(8'hFF, 6);
    do_latch(1'b0, 1'b0);
    chk("t3_q", link.q, 8'hFC);
    chk("t3_err", last_err, 1'b1);

    // 4: over-length frame, counter saturates
    send_bit(1'b1);
    send_bit(1'b1);
    send_word(8'hA5, 8);
    tick(2);
    chk("t4_bit_count_sat", link.bit_count, 9);
    do_latch(1'b0, 1'b0);
    chk("t4_q", link.q, 8'hA5);
    chk("t4_err", last_err, 1'b1);

    // 5: reset mid-frame, then a clean frame
    send_word(8'hFF, 4);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_q", link.q, 8'h00);
    chk("t5_rst_count", link.bit_count, 0);
    rst = 1'b0;
    model_reset();
    tick(4);
    chk("t5_post_q", link.q, 8'h00);
    chk("t5_post_count", link.bit_count, 0);
    send_word(8'h3C, 8);
    do_latch(1'b0, 1'b0);
    chk("t5_q", link.q, 8'h3C);
    chk("t5_err", last_err, 1'b0);

    // 6: latch coincident with first shift of the next frame (0xC3, bit0 = 1)
    send_word(8'h5A, 8);
    do_latch(1'b1, 1'b1);
    chk("t6_q", link.q, 8'h5A);
    chk("t6_err", last_err, 1'b0);
    chk("t6_bit_count", link.bit_count, 1);
    for (int i = 1; i < W; i++) send_bit(1'((8'hC3 >> i) & 8'h01));
    do_latch(1'b0, 1'b0);
    chk("t6_next_q", link.q, 8'hC3);
    chk("t6_next_err", last_err, 1'b0);

    // Latch with zero shifts re-latches the same word and flags it
    do_latch(1'b0, 1'b0);
    chk("t7_q", link.q, 8'hC3);
    chk("t7_err", last_err, 1'b1);

    tick(10);
    chk("pending_expectations", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
